regfile_scoreboard: RTL and testbench

//  Parametrised three-port register file (2 read, 1 write) with a per-register pending scoreboard and a synchronous clear.

---
 rtl/regfile_scoreboard_pkg.sv | 10 +
 rtl/regfile_scoreboard_pend.sv | 65 ++++++
 rtl/regfile_scoreboard.sv | 90 +++++++++
 tb/tb_regfile_scoreboard.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults for the register file / scoreboard slice: data width,
// address width, hardwired-zero default and the register-0 index.
package regfile_scoreboard_pkg;

    localparam int unsigned RF_WIDTH    = 16;
    localparam int unsigned RF_REGBITS  = 4;
    localparam int unsigned RF_ZERO_REG = 1;
    localparam int unsigned RF_REG0     = 0;

endpackage

// File: rtl/regfile_scoreboard_pend.sv
// Pending-destination scoreboard: one bit per register, set by accepted
// issues and cleared by writeback (set wins on a same-register collision).
// It produces the WAW issue stall and a count of in-flight destinations.
module regfile_scoreboard_pend
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned REGBITS  = RF_REGBITS,
    parameter int unsigned ZERO_REG = RF_ZERO_REG
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       regwrite,
    input  logic [REGBITS-1:0]         wa,
    input  logic                       issue,
    input  logic [REGBITS-1:0]         issue_wa,
    output logic [(1<<REGBITS)-1:0]    pending,
    output logic                       issue_stall,
    output logic [REGBITS:0]           pend_cnt
);

    localparam int unsigned NREGS = 1 << REGBITS;
    localparam int unsigned CW    = REGBITS + 1;

    logic             wa_zero;
    logic             iwa_zero;
    logic             clr;
    logic             set;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] pend_nxt;
    logic [CW-1:0]    cnt_nxt;

    // Stall decision, set/clear priority and counter delta for this cycle
    always_comb begin
        wa_zero     = (ZERO_REG != 0) && (wa == REGBITS'(RF_REG0));
        iwa_zero    = (ZERO_REG != 0) && (issue_wa == REGBITS'(RF_REG0));
        clr         = regwrite && !wa_zero;
        // A writeback to the same register frees it this cycle, so no WAW stall
        issue_stall = issue && pending[issue_wa] && !(regwrite && (wa == issue_wa)) && !iwa_zero;
        set         = issue && !issue_stall && !iwa_zero;

        pend_nxt = pending;
        if (clr) pend_nxt[wa] = 1'b0;
        if (set) pend_nxt[issue_wa] = 1'b1;

        inc = set && !pending[issue_wa];
        dec = clr && pending[wa] && !(set && (issue_wa == wa));

        cnt_nxt = pend_cnt;
        if (inc && !dec)      cnt_nxt = pend_cnt + CW'(1);
        else if (dec && !inc) cnt_nxt = pend_cnt - CW'(1);
    end

    // Scoreboard state, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read / 1-write register file with a pending-register scoreboard.
// Optional RF_BYPASS_EN: forwards same-cycle writeback data to the read
// ports and masks their busy flags; undefined, reads see pre-write state.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned REGBITS  = RF_REGBITS,
    parameter int unsigned ZERO_REG = RF_ZERO_REG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                regwrite,
    input  logic [REGBITS-1:0]  wa,
    input  logic [WIDTH-1:0]    wd,
    input  logic [REGBITS-1:0]  ra1,
    input  logic [REGBITS-1:0]  ra2,
    output logic [WIDTH-1:0]    rd1,
    output logic [WIDTH-1:0]    rd2,
    output logic                rd1_busy,
    output logic                rd2_busy,
    input  logic                issue,
    input  logic [REGBITS-1:0]  issue_wa,
    output logic                issue_stall,
    output logic [REGBITS:0]    pend_cnt
);

    localparam int unsigned NREGS = 1 << REGBITS;

    logic [WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0] pending;
    logic             wr_en;

    regfile_scoreboard_pend #(
        .REGBITS  (REGBITS),
        .ZERO_REG (ZERO_REG)
    ) u_pend (
        .clk         (clk),
        .reset       (reset),
        .regwrite    (regwrite),
        .wa          (wa),
        .issue       (issue),
        .issue_wa    (issue_wa),
        .pending     (pending),
        .issue_stall (issue_stall),
        .pend_cnt    (pend_cnt)
    );

    // Writes to the hardwired zero register are dropped
    always_comb begin
        wr_en = regwrite && !((ZERO_REG != 0) && (wa == REGBITS'(RF_REG0)));
    end

    // Storage array, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // Read muxes with hardwired zero and optional writeback forwarding
    always_comb begin
        rd1      = mem[ra1];
        rd1_busy = pending[ra1];
        rd2      = mem[ra2];
        rd2_busy = pending[ra2];
`ifdef RF_BYPASS_EN
        if (wr_en && (wa == ra1)) begin
            rd1      = wd;
            rd1_busy = 1'b0;
        end
        if (wr_en && (wa == ra2)) begin
            rd2      = wd;
            rd2_busy = 1'b0;
        end
`else
`endif
        if ((ZERO_REG != 0) && (ra1 == REGBITS'(RF_REG0))) begin
            rd1      = '0;
            rd1_busy = 1'b0;
        end
        if ((ZERO_REG != 0) && (ra2 == REGBITS'(RF_REG0))) begin
            rd2      = '0;
            rd2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (default parameters, ZERO_REG=1).
// Reference model: plain arrays of register values and pending flags,
// with the count taken as the number of set flags.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra1, ra2;
    logic [15:0] rd1, rd2;
    logic        rd1_busy, rd2_busy;
    logic        issue;
    logic [3:0]  issue_wa;
    logic        issue_stall;
    logic [4:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_mem  [16];
    bit          m_pend [16];

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .regwrite    (regwrite),
        .wa          (wa),
        .wd          (wd),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .rd1_busy    (rd1_busy),
        .rd2_busy    (rd2_busy),
        .issue       (issue),
        .issue_wa    (issue_wa),
        .issue_stall (issue_stall),
        .pend_cnt    (pend_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [3:0] ra);
        if (ra == 4'd0) return 16'h0;
`ifdef RF_BYPASS_EN
        if (regwrite && wa != 4'd0 && wa == ra) return wd;
`endif
        return m_mem[ra];
    endfunction

    function automatic bit exp_busy(input logic [3:0] ra);
        if (ra == 4'd0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (regwrite && wa != 4'd0 && wa == ra) return 1'b0;
`endif
        return m_pend[ra];
    endfunction

    // Apply one cycle of inputs, check outputs before the edge, advance the model
    task automatic step(input bit rst, input bit rw, input logic [3:0] w_a, input logic [15:0] w_d,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input bit iss, input logic [3:0] iwa);
        bit st;
        reset = rst; regwrite = rw; wa = w_a; wd = w_d;
        ra1 = r1; ra2 = r2; issue = iss; issue_wa = iwa;
        #2;
        st = iss && iwa != 4'd0 && m_pend[iwa] && !(rw && w_a == iwa);
        check("rd1", 32'(rd1), 32'(exp_rd(r1)));
        check("rd2", 32'(rd2), 32'(exp_rd(r2)));
        check("rd1_busy", 32'(rd1_busy), 32'(exp_busy(r1)));
        check("rd2_busy", 32'(rd2_busy), 32'(exp_busy(r2)));
        check("issue_stall", 32'(issue_stall), 32'(st));
        check("pend_cnt", 32'(pend_cnt), 32'(model_count()));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[i]  = 16'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (rw && w_a != 4'd0) begin
                m_mem[w_a]  = w_d;
                m_pend[w_a] = 1'b0;
            end
            if (iss && iwa != 4'd0 && !st) m_pend[iwa] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
        step(0, 0, 4'd0, 16'h0, r1, r2, 0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = 16'h0;
            m_pend[i] = 1'b0;
        end
        reset = 1'b1; regwrite = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; issue = 1'b0; issue_wa = '0;
        @(posedge clk); #1;
        check("reset_cnt", 32'(pend_cnt), 32'd0);

        // Reset mid-run with regs 3 and 5 pending
        step(0, 1, 4'd3, 16'h1111, 4'd3, 4'd5, 1, 4'd3);
        step(0, 0, 4'd0, 16'h0, 4'd3, 4'd5, 1, 4'd5);
        check("pend_before_reset", 32'(pend_cnt), 32'd2);
        step(1, 1, 4'd6, 16'h2222, 4'd3, 4'd5, 1, 4'd6);
        check("reset_cnt_mid", 32'(pend_cnt), 32'd0);
        ra1 = 4'd3; #1;
        check("reset_rd1", 32'(rd1), 32'd0);
        check("reset_rd1_busy", 32'(rd1_busy), 32'd0);
        idle(4'd3, 4'd6);

        // Write/read same register in one cycle
        step(0, 1, 4'd4, 16'h1234, 4'd4, 4'd0, 0, 4'd0);
        step(0, 1, 4'd4, 16'hBEEF, 4'd4, 4'd4, 0, 4'd0);
        idle(4'd4, 4'd4);
        check("rd1_after_write", 32'(rd1), 32'h0000BEEF);

        // Issue 7, then re-issue while pending
        step(0, 0, 4'd0, 16'h0, 4'd0, 4'd7, 1, 4'd7);
        check("cnt_after_issue7", 32'(pend_cnt), 32'd1);
        step(0, 0, 4'd0, 16'h0, 4'd0, 4'd7, 1, 4'd7);
        check("cnt_after_reissue7", 32'(pend_cnt), 32'd1);

        // Clear and issue 7 together: set wins
        step(0, 1, 4'd7, 16'h7777, 4'd7, 4'd7, 1, 4'd7);
        check("cnt_set_wins", 32'(pend_cnt), 32'd1);
        idle(4'd7, 4'd0);
        step(0, 1, 4'd7, 16'hA5A5, 4'd7, 4'd0, 0, 4'd0);

        // Hardwired zero register
        step(0, 1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1, 4'd0);
        idle(4'd0, 4'd0);
        check("zero_rd1", 32'(rd1), 32'd0);
        check("zero_cnt", 32'(pend_cnt), 32'd0);

        // Fill all non-zero registers, then retire them
        for (int r = 1; r < 16; r++) step(0, 0, 4'd0, 16'h0, 4'(r), 4'(r - 1), 1, 4'(r));
        check("cnt_full", 32'(pend_cnt), 32'd15);
        step(0, 0, 4'd0, 16'h0, 4'd1, 4'd15, 1, 4'd9);
        check("cnt_full_hold", 32'(pend_cnt), 32'd15);
        for (int r = 1; r < 16; r++) step(0, 1, 4'(r), 16'(r * 16'h0101), 4'(r), 4'(16 - r), 0, 4'd0);
        check("cnt_drained", 32'(pend_cnt), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
        end
        idle(4'd1, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
